// File: rtl/fft_input_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_input_framer_if
//  Purpose  : Output stream bundle of the FFT input framer. One frame word is
//             offered per cycle under a valid/ready handshake.
//  Signals  : out_data  - frame sample being offered
//             out_valid - out_data/out_index/out_last are meaningful
//             out_ready - sink accepts on out_valid && out_ready
//             out_index - position of the word within its frame, 0..N-1
//             out_last  - marks the final word (index N-1) of a frame
//  Modports : master (framer side), slave (consumer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface fft_input_framer_if #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LOG2_N-1:0] out_index;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_input_framer
//  Purpose  : Captures one sample per rising edge of the divided clock into a
//             ping-pong pair of N-entry frame buffers at the bit-reversed
//             address, then streams completed frames out linearly, which
//             presents them in the bit-reversed order a radix-2 DIT core
//             consumes.
//  Ports    : clk_in    - system clock, all logic on its rising edge
//             rst_n     - asynchronous active-low reset
//             div_clk   - divided clock, synchronous to clk_in
//             sample_in - sample captured on strobe cycles only
//             out_if    - output stream (master modport)
//             overrun   - sticky, a strobe was dropped since reset
//  Revision : 1.0 - initial release
// ============================================================================
module fft_input_framer #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  div_clk,
    input  logic [DATA_W-1:0]     sample_in,
    fft_input_framer_if.master    out_if,
    output logic                  overrun
);

    localparam int                c_depth = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] c_last  = LOG2_N'(c_depth - 1);

    // Address bit reversal applied on the write side so that a plain linear
    // read produces the butterfly input order.
    function automatic logic [LOG2_N-1:0] f_bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

    logic                r_div_q;
    logic [DATA_W-1:0]   r_buf [2][c_depth];
    logic [1:0]          r_full;
    logic                r_wr_sel;
    logic                r_rd_sel;
    logic [LOG2_N-1:0]   r_wr_cnt;
    logic [LOG2_N-1:0]   r_rd_cnt;
    logic                r_overrun;

    logic                w_strobe;
    logic                w_wr_ok;
    logic                w_drop;
    logic                w_wr_last;
    logic                w_rd_xfer;
    logic                w_rd_last;
    logic [LOG2_N-1:0]   w_wr_addr;
    logic [1:0]          w_full_nxt;

    // div_q resets high so a div_clk already high at reset release is not
    // mistaken for a rising edge.
    assign w_strobe  = div_clk & ~r_div_q;

    // The full flag is sampled before this cycle's read completion, so a
    // strobe arriving as its bank is being freed is still dropped.
    assign w_wr_ok   = w_strobe &  ~r_full[r_wr_sel];
    assign w_drop    = w_strobe &   r_full[r_wr_sel];
    assign w_wr_last = (r_wr_cnt == c_last);
    assign w_wr_addr = f_bitrev(r_wr_cnt);

    assign w_rd_xfer = out_if.out_valid & out_if.out_ready;
    assign w_rd_last = (r_rd_cnt == c_last);

    // Writer only touches a non-full bank and reader only a full one, so the
    // set and the clear below never collide on the same bank.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_ok && w_wr_last) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_rd_xfer && w_rd_last) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q   <= 1'b1;
            r_full    <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_div_q <= div_clk;
            r_full  <= w_full_nxt;

            if (w_wr_ok) begin
                if (w_wr_last) begin
                    r_wr_cnt <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (w_rd_xfer) begin
                if (w_rd_last) begin
                    r_rd_cnt <= '0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < c_depth; i++) begin
                    r_buf[b][i] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_buf[r_wr_sel][w_wr_addr] <= sample_in;
        end
    end

    assign out_if.out_valid = r_full[r_rd_sel];
    assign out_if.out_data  = r_buf[r_rd_sel][r_rd_cnt];
    assign out_if.out_index = r_rd_cnt;
    assign out_if.out_last  = r_full[r_rd_sel] & w_rd_last;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_input_framer
//  Purpose  : Directed self-checking bench for fft_input_framer. Expected
//             frame words are queued when samples are driven and compared
//             as the framer hands them out.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_input_framer;

    localparam int DATA_W = 16;
    localparam int LOG2_N = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [LOG2_N-1:0] idx;
        logic              last;
    } exp_t;

    logic              clk_in;
    logic              rst_n;
    logic              div_clk;
    logic [DATA_W-1:0] sample_in;
    logic              overrun;

    fft_input_framer_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_if ();

    fft_input_framer #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .div_clk   (div_clk),
        .sample_in (sample_in),
        .out_if    (u_if),
        .overrun   (overrun)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_last   = 0;
    logic mon_en   = 1'b0;
    exp_t sb [$];

    logic [2:0] br_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Frame samples are base+k; output position i carries sample bitrev(i).
    task automatic push_frame(input logic [DATA_W-1:0] base);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data = base + DATA_W'(br_tab[i]);
            e.idx  = 3'(i);
            e.last = (i == 7);
            sb.push_back(e);
        end
    endtask

    // One divided-clock period of 5 cycles: 2 high, 3 low.
    task automatic strobe_begin(input logic [DATA_W-1:0] s);
        div_clk   = 1'b1;
        sample_in = s;
        tick();
    endtask

    task automatic strobe_end();
        sample_in = ~sample_in;
        tick();
        div_clk = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic strobe_sample(input logic [DATA_W-1:0] s);
        strobe_begin(s);
        strobe_end();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            tick();
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
        check({tag, "_last"},  32'(u_if.out_last),  32'd0);
        check({tag, "_index"}, 32'(u_if.out_index), 32'd0);
        check({tag, "_data"},  32'(u_if.out_data),  32'd0);
        check({tag, "_ovr"},   32'(overrun),        32'd0);
    endtask

    // Output monitor: scoreboard comparison on transfers, stability while
    // the word is stalled.
    logic              p_hold = 1'b0;
    logic [DATA_W-1:0] p_data;
    logic [LOG2_N-1:0] p_idx;
    logic              p_last;
    exp_t              m_e;

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (p_hold) begin
                check("hold_valid", 32'(u_if.out_valid), 32'd1);
                check("hold_data",  32'(u_if.out_data),  32'(p_data));
                check("hold_index", 32'(u_if.out_index), 32'(p_idx));
                check("hold_last",  32'(u_if.out_last),  32'(p_last));
            end
            if (!u_if.out_valid) begin
                check("last_no_valid", 32'(u_if.out_last), 32'd0);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'(u_if.out_data), 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    check("out_data",  32'(u_if.out_data),  32'(m_e.data));
                    check("out_index", 32'(u_if.out_index), 32'(m_e.idx));
                    check("out_last",  32'(u_if.out_last),  32'(m_e.last));
                    if (u_if.out_last) n_last++;
                end
            end
            p_hold <= u_if.out_valid && !u_if.out_ready;
            p_data <= u_if.out_data;
            p_idx  <= u_if.out_index;
            p_last <= u_if.out_last;
        end
    end

    initial begin
        int last_before;

        rst_n          = 1'b0;
        div_clk        = 1'b0;
        sample_in      = '0;
        u_if.out_ready = 1'b0;

        // Reset / idle: div_clk toggles in reset, released while high.
        for (int i = 0; i < 6; i++) begin
            div_clk   = ~div_clk;
            sample_in = 16'hDEAD;
            tick();
        end
        div_clk = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        div_clk = 1'b0;
        tick();
        check_reset_outputs("idle");
        mon_en = 1'b1;

        // Single frame with full-rate drain.
        u_if.out_ready = 1'b1;
        push_frame(16'h0100);
        for (int k = 0; k < 7; k++) strobe_sample(16'h0100 + 16'(k));
        check("lat_valid_before", 32'(u_if.out_valid), 32'd0);
        strobe_begin(16'h0107);
        check("lat_valid_after", 32'(u_if.out_valid), 32'd1);
        check("lat_first_data",  32'(u_if.out_data),  32'h0100);
        check("lat_first_index", 32'(u_if.out_index), 32'd0);
        strobe_end();
        wait_drain("single_drain");
        check("single_ovr",   32'(overrun),         32'd0);
        check("single_last",  32'(n_last),          32'd1);
        check("single_valid", 32'(u_if.out_valid),  32'd0);

        // Backpressure overflow: 17 strobes with the sink stalled.
        u_if.out_ready = 1'b0;
        push_frame(16'h0200);
        push_frame(16'h0208);
        for (int k = 0; k < 16; k++) strobe_sample(16'h0200 + 16'(k));
        check("bp_valid", 32'(u_if.out_valid), 32'd1);
        check("bp_ovr0",  32'(overrun),        32'd0);
        check("bp_data",  32'(u_if.out_data),  32'h0200);
        strobe_begin(16'h0210);
        check("bp_ovr1",  32'(overrun),        32'd1);
        strobe_end();
        u_if.out_ready = 1'b1;
        wait_drain("bp_drain");
        push_frame(16'h0300);
        for (int k = 0; k < 8; k++) strobe_sample(16'h0300 + 16'(k));
        wait_drain("bp_next_drain");
        check("bp_ovr_sticky", 32'(overrun), 32'd1);

        // Ready toggling during drain.
        u_if.out_ready = 1'b0;
        push_frame(16'h0400);
        for (int k = 0; k < 8; k++) strobe_sample(16'h0400 + 16'(k));
        last_before = n_last;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            u_if.out_ready = ~u_if.out_ready;
            tick();
        end
        check("tog_drain", 32'(sb.size()), 32'd0);
        u_if.out_ready = 1'b0;
        tick();
        check("tog_last_once", 32'(n_last - last_before), 32'd1);
        check("tog_valid",     32'(u_if.out_valid),       32'd0);

        // Mid-frame reset after 5 strobes.
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) strobe_sample(16'h0500 + 16'(k));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        push_frame(16'h0600);
        for (int k = 0; k < 8; k++) strobe_sample(16'h0600 + 16'(k));
        wait_drain("midrst_drain");
        check("midrst_ovr", 32'(overrun), 32'd0);

        // Concurrent fill/drain: bank 0 read completes as bank 1 write completes.
        u_if.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        push_frame(16'h0700);
        push_frame(16'h0708);
        for (int k = 0; k < 15; k++) strobe_sample(16'h0700 + 16'(k));
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        u_if.out_ready = 1'b0;
        tick();
        check("cc_index7", 32'(u_if.out_index), 32'd7);
        u_if.out_ready = 1'b1;
        strobe_begin(16'h070F);
        check("cc_valid", 32'(u_if.out_valid), 32'd1);
        check("cc_index", 32'(u_if.out_index), 32'd0);
        check("cc_data",  32'(u_if.out_data),  32'h0708);
        strobe_end();
        wait_drain("cc_drain");
        check("cc_ovr",   32'(overrun),        32'd0);
        check("cc_idle",  32'(u_if.out_valid), 32'd0);

        mon_en = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
